// File: rtl/sumfour_checker.sv
// Receive-side lock/mismatch checker for the two-digit sumfour count stream.
module sumfour_checker #(
  parameter int unsigned STEP     = 1,
  parameter int unsigned LOCK_LEN = 4,
  parameter int unsigned LOSS_LEN = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [3:0]       i_cnt_1,
  input  logic [3:0]       i_cnt_2,
  output logic             o_locked,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [1:0]       o_state
);

  localparam int unsigned GOOD_W = $clog2(LOCK_LEN + 1);
  localparam int unsigned BAD_W  = $clog2(LOSS_LEN + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACQUIRE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  logic [1:0]       r_state;
  logic [3:0]       r_ref_1;
  logic [3:0]       r_ref_2;
  logic [GOOD_W-1:0] r_good_run;
  logic [BAD_W-1:0]  r_bad_run;

  logic [1:0]        w_state_nxt;
  logic [3:0]        w_ref_1_nxt;
  logic [3:0]        w_ref_2_nxt;
  logic [GOOD_W-1:0] w_good_nxt;
  logic [BAD_W-1:0]  w_bad_nxt;
  logic              w_err_nxt;
  logic [ERR_W-1:0]  w_err_cnt_nxt;

  logic [4:0]        w_sum;
  logic [3:0]        w_exp_1;
  logic [3:0]        w_exp_2;
  logic              w_match;
  logic [GOOD_W-1:0] w_good_inc;
  logic [BAD_W-1:0]  w_bad_inc;

  // Predict the next pair from the reference and compare against the sample.
  always_comb begin
    w_sum      = {1'b0, r_ref_1} + 5'(STEP);
    w_exp_1    = w_sum[3:0];
    w_exp_2    = r_ref_2 + {3'b000, w_sum[4]};
    w_match    = (i_cnt_1 == w_exp_1) && (i_cnt_2 == w_exp_2);
    w_good_inc = r_good_run + GOOD_W'(1);
    w_bad_inc  = r_bad_run + BAD_W'(1);
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_ref_1_nxt   = r_ref_1;
    w_ref_2_nxt   = r_ref_2;
    w_good_nxt    = r_good_run;
    w_bad_nxt     = r_bad_run;
    w_err_nxt     = 1'b0;
    w_err_cnt_nxt = o_err_cnt;

    if (!i_en) begin
      w_state_nxt = S_IDLE;
      w_good_nxt  = '0;
      w_bad_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_ref_1_nxt = i_cnt_1;
          w_ref_2_nxt = i_cnt_2;
          w_good_nxt  = '0;
          w_bad_nxt   = '0;
          w_state_nxt = S_ACQUIRE;
        end
        S_ACQUIRE: begin
          // Always resync to the sample; only consecutive matches build lock.
          w_ref_1_nxt = i_cnt_1;
          w_ref_2_nxt = i_cnt_2;
          if (w_match) begin
            if (w_good_inc == GOOD_W'(LOCK_LEN)) begin
              w_state_nxt = S_LOCKED;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
            end else begin
              w_good_nxt = w_good_inc;
            end
          end else begin
            w_good_nxt = '0;
          end
        end
        S_LOCKED: begin
          if (w_match) begin
            w_ref_1_nxt = i_cnt_1;
            w_ref_2_nxt = i_cnt_2;
            w_bad_nxt   = '0;
          end else begin
            w_err_nxt = 1'b1;
            if (o_err_cnt != {ERR_W{1'b1}}) begin
              w_err_cnt_nxt = o_err_cnt + ERR_W'(1);
            end
            if (w_bad_inc == BAD_W'(LOSS_LEN)) begin
              // Lock lost: restart acquisition from this sample.
              w_state_nxt = S_ACQUIRE;
              w_ref_1_nxt = i_cnt_1;
              w_ref_2_nxt = i_cnt_2;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
            end else begin
              // Flywheel: advance on the prediction, not the bad sample.
              w_ref_1_nxt = w_exp_1;
              w_ref_2_nxt = w_exp_2;
              w_bad_nxt   = w_bad_inc;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_good_nxt  = '0;
          w_bad_nxt   = '0;
        end
      endcase
    end
  end

  // State, reference, run counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ref_1    <= '0;
      r_ref_2    <= '0;
      r_good_run <= '0;
      r_bad_run  <= '0;
      o_locked   <= 1'b0;
      o_err      <= 1'b0;
      o_err_cnt  <= '0;
      o_state    <= S_IDLE;
    end else begin
      r_state    <= w_state_nxt;
      r_ref_1    <= w_ref_1_nxt;
      r_ref_2    <= w_ref_2_nxt;
      r_good_run <= w_good_nxt;
      r_bad_run  <= w_bad_nxt;
      o_locked   <= (w_state_nxt == S_LOCKED);
      o_err      <= w_err_nxt;
      o_err_cnt  <= w_err_cnt_nxt;
      o_state    <= w_state_nxt;
    end
  end

endmodule

// File: tb/tb_sumfour_checker.sv
// Directed vector bench for sumfour_checker.
module tb_sumfour_checker;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] c1, c2;
  logic       locked, err;
  logic [7:0] err_cnt;
  logic [1:0] state;

  logic       rst2, en2;
  logic [3:0] d1, d2;
  logic       locked2, err2;
  logic [7:0] err_cnt2;
  logic [1:0] state2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sumfour_checker dut (
    .clk(clk), .rst(rst), .i_en(en), .i_cnt_1(c1), .i_cnt_2(c2),
    .o_locked(locked), .o_err(err), .o_err_cnt(err_cnt), .o_state(state)
  );

  sumfour_checker #(.STEP(1), .LOCK_LEN(4), .LOSS_LEN(1000), .ERR_W(8)) dut2 (
    .clk(clk), .rst(rst2), .i_en(en2), .i_cnt_1(d1), .i_cnt_2(d2),
    .o_locked(locked2), .o_err(err2), .o_err_cnt(err_cnt2), .o_state(state2)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] c1;
    logic [3:0] c2;
    logic       locked;
    logic       err;
    logic [7:0] cnt;
    logic [1:0] state;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input int a, input int b,
                     input logic l, input logic er, input int cn, input int s);
    vec_t v;
    v.rst = r; v.en = e; v.c1 = 4'(a); v.c2 = 4'(b);
    v.locked = l; v.err = er; v.cnt = 8'(cn); v.state = 2'(s);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d, want %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [3:0] m1, m2, e1, e2;
    logic [4:0] sum;
    int want;

    rst = 1'b1; en = 1'b0; c1 = '0; c2 = '0;
    rst2 = 1'b1; en2 = 1'b0; d1 = '0; d2 = '0;

    // reset
    add(1,0, 0,0, 0,0,0,0);
    // lock on 0..4
    add(0,1, 0,0, 0,0,0,1); add(0,1, 1,0, 0,0,0,1); add(0,1, 2,0, 0,0,0,1);
    add(0,1, 3,0, 0,0,0,1); add(0,1, 4,0, 1,0,0,2);
    // low-digit carry into high digit, no error
    add(0,0, 0,0, 0,0,0,0);
    add(0,1, 9,3, 0,0,0,1); add(0,1,10,3, 0,0,0,1); add(0,1,11,3, 0,0,0,1);
    add(0,1,12,3, 0,0,0,1); add(0,1,13,3, 1,0,0,2);
    add(0,1,14,3, 1,0,0,2); add(0,1,15,3, 1,0,0,2); add(0,1, 0,4, 1,0,0,2);
    add(0,1, 1,4, 1,0,0,2);
    // missing carry -> one error, flywheel keeps (1,4) valid
    add(0,0, 0,0, 0,0,0,0);
    add(0,1, 9,3, 0,0,0,1); add(0,1,10,3, 0,0,0,1); add(0,1,11,3, 0,0,0,1);
    add(0,1,12,3, 0,0,0,1); add(0,1,13,3, 1,0,0,2);
    add(0,1,14,3, 1,0,0,2); add(0,1,15,3, 1,0,0,2); add(0,1, 0,3, 1,1,1,2);
    add(0,1, 1,4, 1,0,1,2);
    // single glitch then flywheel accepts next expected value
    add(0,0, 0,0, 0,0,1,0);
    add(0,1, 1,2, 0,0,1,1); add(0,1, 2,2, 0,0,1,1); add(0,1, 3,2, 0,0,1,1);
    add(0,1, 4,2, 0,0,1,1); add(0,1, 5,2, 1,0,1,2);
    add(0,1, 6,2, 1,0,1,2); add(0,1, 9,2, 1,1,2,2); add(0,1, 8,2, 1,0,2,2);
    add(0,1, 9,2, 1,0,2,2);
    // disable while locked keeps the error count
    add(0,0, 0,0, 0,0,2,0);
    // three bad samples lose lock, four good relock
    add(0,1, 0,0, 0,0,2,1); add(0,1, 1,0, 0,0,2,1); add(0,1, 2,0, 0,0,2,1);
    add(0,1, 3,0, 0,0,2,1); add(0,1, 4,0, 1,0,2,2);
    add(0,1, 9,9, 1,1,3,2); add(0,1, 9,9, 1,1,4,2); add(0,1, 9,9, 0,1,5,1);
    add(0,1,10,9, 0,0,5,1); add(0,1,11,9, 0,0,5,1); add(0,1,12,9, 0,0,5,1);
    add(0,1,13,9, 1,0,5,2);
    // high-digit wrap 15 -> 0 is silent
    add(0,0, 0,0, 0,0,5,0);
    add(0,1,13,15, 0,0,5,1); add(0,1,14,15, 0,0,5,1); add(0,1,15,15, 0,0,5,1);
    add(0,1, 0,0, 0,0,5,1); add(0,1, 1,0, 1,0,5,2); add(0,1, 2,0, 1,0,5,2);
    // reset mid-lock overrides enable
    add(1,1, 3,0, 0,0,0,0);
    // acquire mismatch resyncs and restarts the good run
    add(0,1, 5,5, 0,0,0,1); add(0,1, 6,5, 0,0,0,1); add(0,1, 9,9, 0,0,0,1);
    add(0,1,10,9, 0,0,0,1); add(0,1,11,9, 0,0,0,1); add(0,1,12,9, 0,0,0,1);
    add(0,1,13,9, 1,0,0,2);

    @(negedge clk);
    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; c1 = tbl[i].c1; c2 = tbl[i].c2;
      @(posedge clk); #1;
      chk("locked", i, int'(locked), int'(tbl[i].locked));
      chk("err", i, int'(err), int'(tbl[i].err));
      chk("err_cnt", i, int'(err_cnt), int'(tbl[i].cnt));
      chk("state", i, int'(state), int'(tbl[i].state));
    end

    // Saturation on the second instance with loss disabled in practice.
    rst = 1'b0; en = 1'b0;
    rst2 = 1'b1; en2 = 1'b0;
    @(posedge clk); #1;
    rst2 = 1'b0; en2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d1 = 4'(k); d2 = 4'd0;
      @(posedge clk); #1;
    end
    chk("sat_lock", 0, int'(locked2), 1);
    m1 = 4'd4; m2 = 4'd0;
    for (int k = 1; k <= 300; k++) begin
      sum = {1'b0, m1} + 5'd1;
      e1 = sum[3:0];
      e2 = m2 + {3'b000, sum[4]};
      d1 = e1 + 4'd3; d2 = e2;
      @(posedge clk); #1;
      want = (k > 255) ? 255 : k;
      chk("sat_err", k, int'(err2), 1);
      chk("sat_cnt", k, int'(err_cnt2), want);
      m1 = e1; m2 = e2;
    end
    chk("sat_still_locked", 300, int'(locked2), 1);
    chk("sat_state", 300, int'(state2), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
